// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with 50% duty for even and odd ratios.
// Ratio changes are deferred to the next period boundary so o_clk never glitches.
module clk_div_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEFAULT_RATIO = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_ratio,
    input  logic             i_ratio_vld,
    output logic             o_ratio_rdy,
    output logic             o_clk,
    output logic [WIDTH-1:0] o_ratio_cur,
    output logic             o_busy,
    output logic             o_err
);

    typedef enum logic [1:0] {StIdle, StRun, StPend, StStop} state_e;

    localparam logic [WIDTH-1:0] DefRatio = WIDTH'(DEFAULT_RATIO);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             div_p_q, div_p_d;
    logic             div_n_q;
    logic             err_q, err_d;

    logic             last;
    logic             xfer;
    logic             legal;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] half;
    logic             run_div;

    assign o_ratio_rdy = (state_q == StIdle) || (state_q == StRun);
    assign xfer        = i_ratio_vld && o_ratio_rdy;
    assign legal       = i_ratio >= WIDTH'(2);
    assign last        = cnt_q == (ratio_q - WIDTH'(1));
    assign cnt_inc     = last ? '0 : cnt_q + WIDTH'(1);
    // ceil(N/2) stays within WIDTH bits even for N = 2^WIDTH-1
    assign half        = (ratio_q >> 1) + {{(WIDTH-1){1'b0}}, ratio_q[0]};
    assign run_div     = cnt_inc < half;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        pending_d = pending_q;
        div_p_d   = div_p_q;
        err_d     = xfer && !legal;
        unique case (state_q)
            StIdle: begin
                if (xfer && legal) ratio_d = i_ratio;
                if (i_en) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    div_p_d = 1'b1;
                end
            end
            StRun: begin
                cnt_d   = cnt_inc;
                div_p_d = run_div;
                if (xfer && legal) begin
                    pending_d = i_ratio;
                    state_d   = StPend;
                end else if (!i_en) begin
                    state_d = StStop;
                end
            end
            StPend: begin
                if (last) begin
                    ratio_d = pending_q;
                    cnt_d   = '0;
                    div_p_d = i_en;
                    state_d = i_en ? StRun : StIdle;
                end else begin
                    cnt_d   = cnt_inc;
                    div_p_d = run_div;
                end
            end
            StStop: begin
                if (!i_en && last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    div_p_d = 1'b0;
                end else begin
                    if (i_en) state_d = StRun;
                    cnt_d   = cnt_inc;
                    div_p_d = run_div;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ratio_q   <= DefRatio;
            pending_q <= DefRatio;
            div_p_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            pending_q <= pending_d;
            div_p_q   <= div_p_d;
            err_q     <= err_d;
        end
    end

    // Half-cycle delayed copy trims odd-ratio high phase to exactly N/2 cycles
    always_ff @(negedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) div_n_q <= 1'b0;
        else          div_n_q <= div_p_q;
    end

    assign o_clk       = ratio_q[0] ? (div_p_q & div_n_q) : div_p_q;
    assign o_ratio_cur = ratio_q;
    assign o_busy      = state_q != StIdle;
    assign o_err       = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a period-level reference model.
// o_clk is predicted per half-cycle of the current period, checked on both edges.
module tb_clk_div_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] ratio;
    logic       vld;
    logic       rdy;
    logic       oclk;
    logic [7:0] cur;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Reference model: period position in whole cycles, plus request flags
    bit m_run, m_pend, m_stop, m_err;
    int m_ratio, m_pos, m_pend_val;

    clk_div_ctrl #(.WIDTH(8), .DEFAULT_RATIO(5)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_ratio     (ratio),
        .i_ratio_vld (vld),
        .o_ratio_rdy (rdy),
        .o_clk       (oclk),
        .o_ratio_cur (cur),
        .o_busy      (busy),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_stop = 0; m_err = 0;
        m_ratio = 5; m_pos = 0; m_pend_val = 5;
    endtask

    // Divided clock is high for N half-cycles; odd ratios start half a cycle late
    function automatic logic exp_clk(input int h);
        if (!m_run) return 1'b0;
        if (m_ratio % 2 == 1) return (h >= 1) && (h <= m_ratio);
        return h < m_ratio;
    endfunction

    function automatic logic exp_rdy();
        return !m_run || (!m_pend && !m_stop);
    endfunction

    task automatic model_edge();
        bit xfer, legal, last;
        xfer  = vld && exp_rdy();
        legal = ratio >= 2;
        m_err = xfer && !legal;
        if (!m_run) begin
            if (xfer && legal) m_ratio = ratio;
            if (en) begin
                m_run = 1; m_pos = 0; m_pend = 0; m_stop = 0;
            end
        end else begin
            last = (m_pos == m_ratio - 1);
            if (m_pend) begin
                if (last) begin
                    m_ratio = m_pend_val; m_pend = 0; m_pos = 0; m_run = en;
                end else begin
                    m_pos++;
                end
            end else if (m_stop && !en && last) begin
                m_run = 0; m_pos = 0; m_stop = 0;
            end else begin
                if (m_stop) m_stop = !en;
                else if (xfer && legal) begin
                    m_pend = 1; m_pend_val = ratio;
                end else if (!en) m_stop = 1;
                m_pos = last ? 0 : m_pos + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_pos", oclk, exp_clk(2 * m_pos));
        chk("busy", busy, m_run);
        chk("ratio_cur", cur, m_ratio);
        chk("err", err, m_err);
        chk("rdy", rdy, exp_rdy());
        @(negedge clk);
        #1;
        chk("clk_neg", oclk, exp_clk(2 * m_pos + 1));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input int r);
        ratio = 8'(r);
        vld   = 1'b1;
        step();
        vld   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; vld = 1'b0; ratio = '0;
        model_reset();
        #22;
        chk("rst_clk", oclk, 0);
        chk("rst_ratio", cur, 5);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", rdy, 1);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // Default ratio 5 straight out of reset
        en = 1'b1;
        steps(16);
        // Even ratio 4 loaded while idle
        en = 1'b0;
        steps(6);
        write(4);
        en = 1'b1;
        steps(12);
        // Mid-run retarget to 8, then illegal ratios
        write(8);
        steps(20);
        write(1);
        steps(2);
        write(0);
        steps(4);
        // Ratio 7 then drop enable mid-period, then restart
        write(7);
        steps(10);
        en = 1'b0;
        steps(14);
        en = 1'b1;
        steps(10);
        // Same-edge write and enable from idle
        en = 1'b0;
        steps(12);
        ratio = 8'd3; vld = 1'b1; en = 1'b1;
        step();
        vld = 1'b0;
        steps(9);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            vld   = ($urandom_range(0, 5) == 0);
            ratio = 8'($urandom_range(0, 15));
            step();
        end
        vld = 1'b0;

        // Widest ratio, then asynchronous reset deep in the high phase
        en = 1'b0;
        steps(20);
        write(255);
        en = 1'b1;
        steps(60);
        chk("wide_high", oclk, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_clk", oclk, 0);
        chk("arst_ratio", cur, 5);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", rdy, 1);
        #20;
        chk("arst_hold", oclk, 0);
        rst_n = 1'b1;
        steps(6);
        steps(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
